// File: rtl/sram_axi_bridge.sv
// SRAM-like core data port to single-beat AXI3 master bridge, one transaction in flight.
// Optional: SRAM_AXI_WRITE_EARLY_ACK_EN acknowledges stores at AW/W completion and tracks B responses.
module sram_axi_bridge #(
    parameter logic [3:0] AXI_ID = 4'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata_axi,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata_axi,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready,
    output logic [3:0]  arid,
    output logic [3:0]  awid,
    output logic [3:0]  wid,
    output logic [3:0]  arlen,
    output logic [3:0]  awlen,
    output logic [1:0]  arburst,
    output logic [1:0]  awburst,
    output logic [1:0]  arlock,
    output logic [1:0]  awlock,
    output logic [3:0]  arcache,
    output logic [3:0]  awcache,
    output logic [2:0]  arprot,
    output logic [2:0]  awprot,
    output logic        wlast
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_WR_REQ,
        S_WR_RESP
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_size;
    logic [3:0]  r_wstrb;
    logic        r_aw_done;
    logic        r_w_done;
    logic [3:0]  w_wstrb;
    logic        w_wr_fin;
    logic        w_gate;

    // Both write channels finished, counting a handshake landing this cycle.
    assign w_wr_fin = (r_state == S_WR_REQ) && (r_aw_done || awready) && (r_w_done || wready);

`ifdef SRAM_AXI_WRITE_EARLY_ACK_EN
    logic [1:0] r_b_pend;

    // Reads wait for all outstanding B responses; writes stall only when the counter is full.
    assign w_gate = wr ? (r_b_pend != 2'd3) : (r_b_pend == 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_b_pend <= 2'd0;
        end else begin
            case ({w_wr_fin, bvalid})
                2'b10:   r_b_pend <= r_b_pend + 2'd1;
                2'b01:   r_b_pend <= (r_b_pend != 2'd0) ? r_b_pend - 2'd1 : 2'd0;
                default: r_b_pend <= r_b_pend;
            endcase
        end
    end
`else
    assign w_gate = 1'b1;
`endif

    always_comb begin
        case (size)
            2'd0:    w_wstrb = 4'b0001 << addr[1:0];
            2'd1:    w_wstrb = 4'b0011 << {addr[1], 1'b0};
            default: w_wstrb = 4'b1111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        addr_ok = 1'b0;
        data_ok = 1'b0;
        arvalid = 1'b0;
        rready  = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
`ifdef SRAM_AXI_WRITE_EARLY_ACK_EN
        bready  = 1'b1;
`else
        bready  = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (req && w_gate) begin
                    addr_ok = 1'b1;
                    w_next  = wr ? S_WR_REQ : S_RD_ADDR;
                end
            end
            S_RD_ADDR: begin
                arvalid = 1'b1;
                if (arready) w_next = S_RD_DATA;
            end
            S_RD_DATA: begin
                rready = 1'b1;
                if (rvalid) begin
                    data_ok = 1'b1;
                    w_next  = S_IDLE;
                end
            end
            S_WR_REQ: begin
                awvalid = !r_aw_done;
                wvalid  = !r_w_done;
                if (w_wr_fin) begin
`ifdef SRAM_AXI_WRITE_EARLY_ACK_EN
                    data_ok = 1'b1;
                    w_next  = S_IDLE;
`else
                    w_next  = S_WR_RESP;
`endif
                end
            end
            S_WR_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    data_ok = 1'b1;
                    w_next  = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Request holding registers and per-channel write completion flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_size    <= 2'd0;
            r_wstrb   <= 4'd0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else if (addr_ok) begin
            r_addr    <= addr;
            r_wdata   <= wdata;
            r_size    <= size;
            r_wstrb   <= w_wstrb;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else if (r_state == S_WR_REQ) begin
            r_aw_done <= r_aw_done || awready;
            r_w_done  <= r_w_done || wready;
        end
    end

    assign rdata     = rdata_axi;
    assign araddr    = r_addr;
    assign awaddr    = r_addr;
    assign arsize    = {1'b0, r_size};
    assign awsize    = {1'b0, r_size};
    assign wdata_axi = r_wdata;
    assign wstrb     = r_wstrb;

    assign arid    = AXI_ID;
    assign awid    = AXI_ID;
    assign wid     = AXI_ID;
    assign arlen   = 4'd0;
    assign awlen   = 4'd0;
    assign arburst = 2'b01;
    assign awburst = 2'b01;
    assign arlock  = 2'b00;
    assign awlock  = 2'b00;
    assign arcache = 4'd0;
    assign awcache = 4'd0;
    assign arprot  = 3'd0;
    assign awprot  = 3'd0;
    assign wlast   = 1'b1;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed self-checking bench for sram_axi_bridge; follows SRAM_AXI_WRITE_EARLY_ACK_EN if defined.
module tb_sram_axi_bridge;

`ifdef SRAM_AXI_WRITE_EARLY_ACK_EN
    localparam logic EA = 1'b1;
`else
    localparam logic EA = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        addr_ok, data_ok;
    logic [31:0] rdata, araddr, awaddr, wdata_axi, rdata_axi;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready, wlast;
    logic [3:0]  wstrb, arid, awid, wid, arlen, awlen, arcache, awcache;
    logic [1:0]  arburst, awburst, arlock, awlock;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sram_axi_bridge dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata_axi(rdata_axi), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata_axi(wdata_axi), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready),
        .arid(arid), .awid(awid), .wid(wid), .arlen(arlen), .awlen(awlen),
        .arburst(arburst), .awburst(awburst), .arlock(arlock), .awlock(awlock),
        .arcache(arcache), .awcache(awcache), .arprot(arprot), .awprot(awprot), .wlast(wlast)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Move to 1ns after the next rising edge; inputs change here, checks follow after #2.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd0; addr = 32'd0; wdata = 32'd0;
        arready = 1'b0; rvalid = 1'b0; rdata_axi = 32'd0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        #2;
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_awvalid", 32'(awvalid), 32'd0);
        chk("rst_wvalid",  32'(wvalid),  32'd0);
        chk("rst_rready",  32'(rready),  32'd0);
        chk("rst_bready",  32'(bready),  32'(EA));
        chk("rst_data_ok", 32'(data_ok), 32'd0);
        chk("rst_araddr",  araddr,       32'd0);
        chk("const_ids",   {20'd0, arid, awid, wid}, {20'd0, 4'd1, 4'd1, 4'd1});
        chk("const_misc",  {7'd0, arlen, awlen, arburst, awburst, arlock, awlock, wlast},
                           {7'd0, 4'd0, 4'd0, 2'b01, 2'b01, 2'b00, 2'b00, 1'b1});
        chk("const_cp",    {18'd0, arcache, awcache, arprot, awprot}, 32'd0);

        // Load word: accept c0, AR c1, data c2.
        cyc(); req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h1000_0004; arready = 1'b1; #2;
        chk("ld_addr_ok_c0", 32'(addr_ok), 32'd1);
        chk("ld_arvalid_c0", 32'(arvalid), 32'd0);
        cyc(); req = 1'b0; #2;
        chk("ld_arvalid_c1", 32'(arvalid), 32'd1);
        chk("ld_araddr_c1",  araddr,       32'h1000_0004);
        chk("ld_arsize_c1",  32'(arsize),  32'd2);
        chk("ld_data_ok_c1", 32'(data_ok), 32'd0);
        cyc(); arready = 1'b0; rvalid = 1'b1; rdata_axi = 32'hDEAD_BEEF; #2;
        chk("ld_rready_c2",  32'(rready),  32'd1);
        chk("ld_data_ok_c2", 32'(data_ok), 32'd1);
        chk("ld_rdata_c2",   rdata,        32'hDEAD_BEEF);
        cyc(); rvalid = 1'b0; #2;
        chk("ld_data_ok_c3", 32'(data_ok), 32'd0);

        // Store byte at offset 3, simultaneous AW/W handshake.
        req = 1'b1; wr = 1'b1; size = 2'd0; addr = 32'h2000_0003; wdata = 32'hAA00_0000; #2;
        chk("sb_addr_ok", 32'(addr_ok), 32'd1);
        cyc(); req = 1'b0; awready = 1'b1; wready = 1'b1; #2;
        chk("sb_awvalid",  32'(awvalid), 32'd1);
        chk("sb_wvalid",   32'(wvalid),  32'd1);
        chk("sb_wstrb",    32'(wstrb),   32'h8);
        chk("sb_awsize",   32'(awsize),  32'd0);
        chk("sb_awaddr",   awaddr,       32'h2000_0003);
        chk("sb_wdata",    wdata_axi,    32'hAA00_0000);
        chk("sb_early_ok", 32'(data_ok), 32'(EA));
        cyc(); awready = 1'b0; wready = 1'b0; #2;
        chk("sb_awvalid_off", 32'(awvalid), 32'd0);
        chk("sb_wvalid_off",  32'(wvalid),  32'd0);
        chk("sb_bready",      32'(bready),  32'd1);
        chk("sb_no_ok",       32'(data_ok), 32'd0);
        cyc(); bvalid = 1'b1; #2;
        chk("sb_b_data_ok", 32'(data_ok), 32'(!EA));
        cyc(); bvalid = 1'b0;

        // Store half at offset 2.
        req = 1'b1; wr = 1'b1; size = 2'd1; addr = 32'h2000_0002; wdata = 32'h5566_0000; #2;
        chk("sh_addr_ok", 32'(addr_ok), 32'd1);
        cyc(); req = 1'b0; awready = 1'b1; wready = 1'b1; #2;
        chk("sh_wstrb",  32'(wstrb),  32'hC);
        chk("sh_awsize", 32'(awsize), 32'd1);
        cyc(); awready = 1'b0; wready = 1'b0; bvalid = 1'b1; #2;
        chk("sh_b_data_ok", 32'(data_ok), 32'(!EA));
        cyc(); bvalid = 1'b0;

        // Store word with AW at c1, W delayed to c4, B at c6.
        req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h2000_0010; wdata = 32'h0102_0304; #2;
        chk("sd_addr_ok_c0", 32'(addr_ok), 32'd1);
        cyc(); req = 1'b0; awready = 1'b1; #2;
        chk("sd_awvalid_c1", 32'(awvalid), 32'd1);
        chk("sd_wvalid_c1",  32'(wvalid),  32'd1);
        chk("sd_wstrb_c1",   32'(wstrb),   32'hF);
        cyc(); awready = 1'b0; #2;
        chk("sd_awvalid_c2", 32'(awvalid), 32'd0);
        chk("sd_wvalid_c2",  32'(wvalid),  32'd1);
        chk("sd_wdata_c2",   wdata_axi,    32'h0102_0304);
        cyc(); #2;
        chk("sd_wvalid_c3",  32'(wvalid),  32'd1);
        chk("sd_data_ok_c3", 32'(data_ok), 32'd0);
        cyc(); wready = 1'b1; #2;
        chk("sd_wvalid_c4",  32'(wvalid),  32'd1);
        chk("sd_data_ok_c4", 32'(data_ok), 32'(EA));
        cyc(); wready = 1'b0; #2;
        chk("sd_wvalid_c5",  32'(wvalid),  32'd0);
        chk("sd_data_ok_c5", 32'(data_ok), 32'd0);
        cyc(); bvalid = 1'b1; #2;
        chk("sd_data_ok_c6", 32'(data_ok), 32'(!EA));
        cyc(); bvalid = 1'b0; #2;
        chk("sd_data_ok_c7", 32'(data_ok), 32'd0);

        // req held high through a load; the next request is taken the cycle after data_ok.
        req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h1000_0020; #2;
        chk("rh_addr_ok_c0", 32'(addr_ok), 32'd1);
        cyc(); #2;
        chk("rh_addr_ok_c1", 32'(addr_ok), 32'd0);
        cyc(); arready = 1'b1; #2;
        chk("rh_addr_ok_c2", 32'(addr_ok), 32'd0);
        cyc(); arready = 1'b0; #2;
        chk("rh_addr_ok_c3", 32'(addr_ok), 32'd0);
        chk("rh_rready_c3",  32'(rready),  32'd1);
        cyc(); rvalid = 1'b1; rdata_axi = 32'hCAFE_0001; #2;
        chk("rh_data_ok_c4", 32'(data_ok), 32'd1);
        chk("rh_addr_ok_c4", 32'(addr_ok), 32'd0);
        cyc(); rvalid = 1'b0; addr = 32'h1000_0024; #2;
        chk("rh_addr_ok_c5", 32'(addr_ok), 32'd1);
        cyc(); req = 1'b0; arready = 1'b1; #2;
        chk("rh_araddr_c6", araddr, 32'h1000_0024);
        cyc(); arready = 1'b0; rvalid = 1'b1; rdata_axi = 32'h0BAD_F00D; #2;
        chk("rh_rdata_c7", rdata, 32'h0BAD_F00D);
        chk("rh_ok_c7",    32'(data_ok), 32'd1);
        cyc(); rvalid = 1'b0;

        // Reset while in WR_REQ abandons the store.
        req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h4000_0000; wdata = 32'h1111_2222; #2;
        chk("rs_addr_ok", 32'(addr_ok), 32'd1);
        cyc(); req = 1'b0; rst = 1'b1; #2;
        chk("rs_awvalid_pre", 32'(awvalid), 32'd1);
        cyc(); rst = 1'b0; #2;
        chk("rs_awvalid", 32'(awvalid), 32'd0);
        chk("rs_wvalid",  32'(wvalid),  32'd0);
        chk("rs_arvalid", 32'(arvalid), 32'd0);
        chk("rs_data_ok", 32'(data_ok), 32'd0);
        chk("rs_awaddr",  awaddr,       32'd0);
        req = 1'b1; wr = 1'b0; addr = 32'h3000_0000; #1;
        chk("rs_idle_accept", 32'(addr_ok), 32'd1);
        cyc(); req = 1'b0; arready = 1'b1; #2;
        chk("rs_araddr", araddr, 32'h3000_0000);
        cyc(); arready = 1'b0; rvalid = 1'b1; rdata_axi = 32'h1234_5678; #2;
        chk("rs_rdata", rdata, 32'h1234_5678);
        cyc(); rvalid = 1'b0;

`ifdef SRAM_AXI_WRITE_EARLY_ACK_EN
        // Early ack: store completes before B; a following load waits until after bvalid.
        req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h5000_0000; wdata = 32'h7777_8888; #2;
        chk("ea_st_addr_ok", 32'(addr_ok), 32'd1);
        cyc(); req = 1'b0; awready = 1'b1; wready = 1'b1; #2;
        chk("ea_st_data_ok", 32'(data_ok), 32'd1);
        cyc(); awready = 1'b0; wready = 1'b0; req = 1'b1; wr = 1'b0; addr = 32'h5000_0004; #2;
        chk("ea_ld_block_a", 32'(addr_ok), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(); #2;
            chk("ea_ld_block_b", 32'(addr_ok), 32'd0);
        end
        cyc(); bvalid = 1'b1; #2;
        chk("ea_ld_block_bv", 32'(addr_ok), 32'd0);
        chk("ea_bready",      32'(bready),  32'd1);
        cyc(); bvalid = 1'b0; #2;
        chk("ea_ld_accept", 32'(addr_ok), 32'd1);
        cyc(); req = 1'b0; arready = 1'b1; #2;
        chk("ea_ld_araddr", araddr, 32'h5000_0004);
        cyc(); arready = 1'b0; rvalid = 1'b1; rdata_axi = 32'h9999_AAAA; #2;
        chk("ea_ld_data_ok", 32'(data_ok), 32'd1);
        cyc(); rvalid = 1'b0;
`endif

        cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_axi_bridge.md
Name: sram_axi_bridge

Overview:
- Responder end of the core's SRAM-like data interface, i.e. the side that produces addr_ok and data_ok for the pipeline control.
- Accepts one req/wr/size/addr/wdata transaction at a time from the core data port and converts it to a single-beat AXI3 master transaction.
- Returns data_ok/rdata to the core.
- Sits between the EX/WB memory stage and the top-level AXI crossbar.

Parameters:
AXI_ID, 4'd1, constant value driven on arid/awid/wid.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req  in  1  core request valid
wr  in  1  1 = store, 0 = load
size  in  2  0 byte, 1 half, 2 word (3 is treated as word)
addr  in  32  byte address
wdata  in  32  store data
addr_ok  out  1  request accepted this cycle
data_ok  out  1  one-cycle completion pulse
rdata  out  32  load data, valid only with data_ok
araddr/arsize/arvalid  out  32/3/1  AXI read address channel
arready  in  1  AXI
rdata_axi/rvalid  in  32/1  AXI read data; rid, rresp, rlast are ignored
rready  out  1  AXI
awaddr/awsize/awvalid  out  32/3/1  AXI write address channel
awready  in  1  AXI
wdata_axi/wstrb/wvalid  out  32/4/1  AXI write data channel
wready  in  1  AXI
bvalid  in  1  AXI; bid and bresp are ignored
bready  out  1  AXI
arid/awid/wid/arlen/awlen/arburst/awburst/arlock/awlock/arcache/awcache/arprot/awprot/wlast  out  misc  constants: ID=AXI_ID, len=0, burst=2'b01, lock=0, cache=0, prot=0, wlast=1

Behaviour:
- Reset: state IDLE; arvalid, awvalid, wvalid, rready, bready, addr_ok, data_ok all 0; address/data holding registers 0.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- addr_ok = req && state==IDLE (combinational).
  - On acceptance, latch addr, size, wdata, wr and the computed wstrb.
  - Next state: RD_ADDR if wr=0, else WR_REQ.
- RD_ADDR:
  - arvalid=1 with latched addr; arsize={1'b0,size}.
  - On arready, go to RD_DATA.
- RD_DATA:
  - rready=1.
  - On rvalid: data_ok=1 and rdata=rdata_axi in the same cycle (combinational pass-through), then go to IDLE.
- WR_REQ:
  - awvalid and wvalid are raised together.
  - Each channel drops independently after its handshake; done flags aw_done/w_done track this.
  - Go to WR_RESP once both are done; a simultaneous handshake on both completes in one cycle.
- WR_RESP:
  - bready=1.
  - On bvalid: data_ok=1, go to IDLE.
- Load latency: accept in cycle 0; arvalid from cycle 1; earliest data_ok in cycle 2 (arready and rvalid both immediate).
- Back-to-back: the next addr_ok is possible in the cycle after data_ok. Never more than one outstanding transaction.
- wstrb rules:
  - size 0: 4'b0001<<addr[1:0].
  - size 1: 4'b0011<<{addr[1],1'b0}.
  - size 2/3: 4'b1111.
  - wdata is passed unshifted; the core pre-aligns it.
- Misaligned addresses: not checked (the core raises AdEL/AdES before req).
- Valid stability: araddr, awaddr and wdata_axi are held stable while their valid is high.
- Reset mid-operation: abandon the transaction immediately and return to IDLE. Interconnect shares rst, so no AXI protocol recovery is needed.
- req is ignored outside IDLE: addr_ok stays 0 and the core holds req.

Optional Feature:
- Macro SRAM_AXI_WRITE_EARLY_ACK_EN.
- When defined:
  - A write issues data_ok in the cycle its last AW/W handshake completes, then returns to IDLE without waiting for B.
  - A 2-bit counter b_pend increments on that completion and decrements on bvalid&&bready; both events in the same cycle leave it unchanged.
  - bready is held at 1 permanently.
  - addr_ok is gated: a read is blocked while b_pend!=0 (read-after-write ordering); a write is blocked while b_pend==3.
  - Reset clears b_pend.
- When not defined: WR_RESP behaviour as above and no counter exists.

Test Plan:
- Load word addr=0x1000_0004, arready=1, rvalid one cycle later with 0xDEADBEEF -> addr_ok cycle 0, arvalid cycle 1 with araddr=0x1000_0004 and arsize=2, data_ok=1 and rdata=0xDEADBEEF cycle 2.
- Store byte addr=0x...03, wdata=0xAA000000 -> wstrb=4'b1000, awsize=0; half at addr 0x...02 -> wstrb=4'b1100.
- Store with awready at cycle 1 and wready delayed to cycle 4 -> awvalid drops after cycle 1, wvalid stays high to cycle 4; bvalid at cycle 6 -> data_ok exactly at cycle 6.
- req held high while in RD_DATA -> addr_ok stays 0 until the cycle after data_ok, then second request accepted.
- rst asserted while in WR_REQ -> next cycle all valids 0, state IDLE, no data_ok pulse.
- With SRAM_AXI_WRITE_EARLY_ACK_EN: store then load with bvalid delayed 5 cycles -> store data_ok before B, load addr_ok held 0 until the cycle after bvalid.
